// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the cartridge SRAM arbiter.
// Covers the arbiter state encoding, the MCU/DMA requester IDs and the slot length limits.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNES = 2'd1,
    ST_MCU  = 2'd2,
    ST_DMA  = 2'd3
  } state_t;

  typedef enum logic {
    ID_MCU = 1'b0,
    ID_DMA = 1'b1
  } rr_id_t;

  localparam int SLOT_LEN_DEFAULT = 4;
  localparam int SLOT_LEN_MIN     = 2;
  localparam int SLOT_LEN_MAX     = 15;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for the cartridge SRAM arbiter.
// SNES: snes_req is a one-clock strobe with no back-pressure, and snes_done pulses once when that slot ends.
// MCU/DMA: req is a level held with addr/we/wrdata stable until the one-clock ack; rddata is valid from the ack onward.
interface sram_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 8
);
  logic          snes_req;
  logic [AW-1:0] snes_addr;
  logic          snes_we;
  logic          snes_writable;
  logic [DW-1:0] snes_wrdata;
  logic [DW-1:0] snes_rddata;
  logic          snes_done;

  logic          mcu_req;
  logic [AW-1:0] mcu_addr;
  logic          mcu_we;
  logic [DW-1:0] mcu_wrdata;
  logic [DW-1:0] mcu_rddata;
  logic          mcu_ack;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_we;
  logic [DW-1:0] dma_wrdata;
  logic [DW-1:0] dma_rddata;
  logic          dma_ack;

  logic          slave_block;

  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] SRAM_DQ_OUT;
  logic          SRAM_DQ_OE;
  logic [DW-1:0] SRAM_DQ_IN;
  logic          SRAM_WEn;
  logic          SRAM_OEn;
  logic          busy;

  modport slave (
    input  snes_req, snes_addr, snes_we, snes_writable, snes_wrdata,
    output snes_rddata, snes_done,
    input  mcu_req, mcu_addr, mcu_we, mcu_wrdata,
    output mcu_rddata, mcu_ack,
    input  dma_req, dma_addr, dma_we, dma_wrdata,
    output dma_rddata, dma_ack,
    input  slave_block,
    output SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE,
    input  SRAM_DQ_IN,
    output SRAM_WEn, SRAM_OEn, busy
  );

  modport master (
    output snes_req, snes_addr, snes_we, snes_writable, snes_wrdata,
    input  snes_rddata, snes_done,
    output mcu_req, mcu_addr, mcu_we, mcu_wrdata,
    input  mcu_rddata, mcu_ack,
    output dma_req, dma_addr, dma_we, dma_wrdata,
    input  dma_rddata, dma_ack,
    output slave_block,
    input  SRAM_ADDR, SRAM_DQ_OUT, SRAM_DQ_OE,
    output SRAM_DQ_IN,
    input  SRAM_WEn, SRAM_OEn, busy
  );
endinterface

// File: rtl/sram_slot_timer.sv
// Fixed-length access slot timer: counts one slot down from grant, flags the last cycle,
// the write-strobe window, and a registered done pulse on the clock after the last cycle.
module sram_slot_timer
  import sram_arb_pkg::*;
#(
  parameter int SLOT_LEN = SLOT_LEN_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  input  logic active,
  output logic is_last,
  output logic we_window,
  output logic done
);
  localparam logic [3:0] LOAD       = 4'(SLOT_LEN - 1);
  localparam bit         SHORT_SLOT = (SLOT_LEN == SLOT_LEN_MIN);

  logic [3:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= 4'd0;
      done <= 1'b0;
    end else begin
      done <= is_last;
      if (start) begin
        cnt <= LOAD;
      end else if (active && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // cnt == LOAD is cycle 0 and cnt == 0 the last cycle; a two-clock slot strobes on its last cycle.
  always_comb begin
    is_last = active && (cnt == 4'd0);
    if (SHORT_SLOT) begin
      we_window = is_last;
    end else begin
      we_window = active && (cnt != 4'd0) && (cnt != LOAD);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Cartridge SRAM port arbiter: SNES has absolute priority, MCU and DMA share the
// remaining slots round-robin, and every access occupies one fixed-length slot.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SLOT_LEN = SLOT_LEN_DEFAULT,
  parameter int AW       = 24,
  parameter int DW       = 8
) (
  input  logic          CLK,
  input  logic          RST,
  sram_arbiter_if.slave bus,
  output state_t        dbg_state
);
  state_t        state;
  state_t        state_nx;
  state_t        prev_state;
  rr_id_t        rr_last;
  logic          snes_pend;
  logic          snes_we_q;
  logic [AW-1:0] snes_addr_q;
  logic [DW-1:0] snes_wdata_q;
  logic [AW-1:0] slot_addr;
  logic [DW-1:0] slot_wdata;
  logic          slot_we;
  logic [DW-1:0] snes_rd_q;
  logic [DW-1:0] mcu_rd_q;
  logic [DW-1:0] dma_rd_q;
  logic          active;
  logic          grant;
  logic          is_last;
  logic          we_window;
  logic          slot_done;

  assign active = (state != ST_IDLE);
  assign grant  = (state == ST_IDLE) && (state_nx != ST_IDLE);

  sram_slot_timer #(.SLOT_LEN(SLOT_LEN)) u_timer (
    .CLK       (CLK),
    .RST       (RST),
    .start     (grant),
    .active    (active),
    .is_last   (is_last),
    .we_window (we_window),
    .done      (slot_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (snes_pend) begin
          state_nx = ST_SNES;
        end else if (!bus.slave_block) begin
          if (bus.mcu_req && bus.dma_req) begin
            state_nx = (rr_last == ID_DMA) ? ST_MCU : ST_DMA;
          end else if (bus.mcu_req) begin
            state_nx = ST_MCU;
          end else if (bus.dma_req) begin
            state_nx = ST_DMA;
          end
        end
      end
      default: begin
        if (is_last) begin
          state_nx = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_state   <= ST_IDLE;
      rr_last      <= ID_DMA;
      snes_pend    <= 1'b0;
      snes_we_q    <= 1'b0;
      snes_addr_q  <= '0;
      snes_wdata_q <= '0;
      slot_addr    <= '0;
      slot_wdata   <= '0;
      slot_we      <= 1'b0;
      snes_rd_q    <= '0;
      mcu_rd_q     <= '0;
      dma_rd_q     <= '0;
    end else begin
      prev_state <= state;
      // A new strobe outranks the clear, so a request landing on the grant edge is kept for the next slot.
      if (bus.snes_req) begin
        snes_pend    <= 1'b1;
        snes_addr_q  <= bus.snes_addr;
        snes_we_q    <= bus.snes_we & bus.snes_writable;
        snes_wdata_q <= bus.snes_wrdata;
      end else if (grant && (state_nx == ST_SNES)) begin
        snes_pend <= 1'b0;
      end
      if (grant) begin
        case (state_nx)
          ST_SNES: begin
            slot_addr  <= snes_addr_q;
            slot_wdata <= snes_wdata_q;
            slot_we    <= snes_we_q;
          end
          ST_MCU: begin
            slot_addr  <= bus.mcu_addr;
            slot_wdata <= bus.mcu_wrdata;
            slot_we    <= bus.mcu_we;
            rr_last    <= ID_MCU;
          end
          default: begin
            slot_addr  <= bus.dma_addr;
            slot_wdata <= bus.dma_wrdata;
            slot_we    <= bus.dma_we;
            rr_last    <= ID_DMA;
          end
        endcase
      end
      if (is_last && !slot_we) begin
        case (state)
          ST_SNES: snes_rd_q <= bus.SRAM_DQ_IN;
          ST_MCU:  mcu_rd_q  <= bus.SRAM_DQ_IN;
          default: dma_rd_q  <= bus.SRAM_DQ_IN;
        endcase
      end
    end
  end

  // The timer's done pulse lands one clock after the slot, when prev_state still names its owner.
  always_comb begin
    bus.busy        = active;
    bus.SRAM_ADDR   = slot_addr;
    bus.SRAM_DQ_OUT = slot_wdata;
    bus.SRAM_OEn    = ~(active & ~slot_we);
    bus.SRAM_DQ_OE  = active & slot_we;
    bus.SRAM_WEn    = ~(active & slot_we & we_window);
    bus.snes_done   = slot_done && (prev_state == ST_SNES);
    bus.mcu_ack     = slot_done && (prev_state == ST_MCU);
    bus.dma_ack     = slot_done && (prev_state == ST_DMA);
    bus.snes_rddata = snes_rd_q;
    bus.mcu_rddata  = mcu_rd_q;
    bus.dma_rddata  = dma_rd_q;
    dbg_state       = state;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a randomized run scored against a
// transaction-level memory model with an aliasing SRAM model on the pins.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int SL = 4;
  localparam int AW = 24;
  localparam int DW = 8;

  logic   CLK = 1'b0;
  logic   RST = 1'b1;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sram_arbiter #(.SLOT_LEN(SL), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // SRAM device model, indexed by the low address byte
  logic [7:0] sram_mem [256];
  bit         sram_wr  [256];
  logic       dq_force = 1'b0;
  logic [7:0] dq_force_val = 8'h00;
  logic [7:0] exp_mem [logic [23:0]];

  function automatic logic [7:0] dflt(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  function automatic logic [7:0] model_rd(input logic [23:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return dflt(a[7:0]);
  endfunction

  function automatic logic [23:0] raddr();
    return {20'h3C5A2, 4'($urandom_range(0, 15))};
  endfunction

  assign bus.SRAM_DQ_IN = bus.SRAM_OEn ? 8'hEE :
                          dq_force ? dq_force_val :
                          (sram_wr[bus.SRAM_ADDR[7:0]] ? sram_mem[bus.SRAM_ADDR[7:0]] : dflt(bus.SRAM_ADDR[7:0]));

  always @(posedge CLK) begin
    if (!bus.SRAM_WEn) begin
      sram_mem[bus.SRAM_ADDR[7:0]] <= bus.SRAM_DQ_OUT;
      sram_wr[bus.SRAM_ADDR[7:0]]  <= 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic clear_inputs();
    bus.snes_req = 1'b0; bus.snes_addr = '0; bus.snes_we = 1'b0; bus.snes_writable = 1'b0; bus.snes_wrdata = '0;
    bus.mcu_req = 1'b0; bus.mcu_addr = '0; bus.mcu_we = 1'b0; bus.mcu_wrdata = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0; bus.dma_we = 1'b0; bus.dma_wrdata = '0;
    bus.slave_block = 1'b0;
  endtask

  task automatic snes_pulse(input logic [23:0] a, input logic we, input logic wr, input logic [7:0] d);
    bus.snes_addr = a; bus.snes_we = we; bus.snes_writable = wr; bus.snes_wrdata = d;
    bus.snes_req = 1'b1;
    tick();
    bus.snes_req = 1'b0;
  endtask

  task automatic snes_watch(output int busy_n, output int oe_n, output int we_n, output int dqoe_n, output bit seen);
    busy_n = 0; oe_n = 0; we_n = 0; dqoe_n = 0; seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.snes_done) begin
        seen = 1'b1;
        break;
      end
      busy_n += int'(bus.busy);
      oe_n   += int'(!bus.SRAM_OEn);
      we_n   += int'(!bus.SRAM_WEn);
      dqoe_n += int'(bus.SRAM_DQ_OE);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    total++; if ({bus.SRAM_WEn, bus.SRAM_OEn, bus.SRAM_DQ_OE, bus.busy} !== 4'b1100) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=1100", {bus.SRAM_WEn, bus.SRAM_OEn, bus.SRAM_DQ_OE, bus.busy}); end
    total++; if (bus.SRAM_ADDR !== 24'h0 || bus.SRAM_DQ_OUT !== 8'h0) begin bad++;
      $display("FAIL reset_bus addr=%h dq=%h exp=0", bus.SRAM_ADDR, bus.SRAM_DQ_OUT); end
    total++; if ({bus.snes_rddata, bus.mcu_rddata, bus.dma_rddata} !== 24'h0) begin bad++;
      $display("FAIL reset_rddata got=%h exp=0", {bus.snes_rddata, bus.mcu_rddata, bus.dma_rddata}); end
    total++; if ({bus.snes_done, bus.mcu_ack, bus.dma_ack} !== 3'b000) begin bad++;
      $display("FAIL reset_pulses got=%b exp=000", {bus.snes_done, bus.mcu_ack, bus.dma_ack}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    RST = 1'b0;
    tick(); tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_req busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_mcu_read();
    int n_oe;
    bit ack;
    n_oe = 0; ack = 1'b0;
    dq_force = 1'b1; dq_force_val = 8'hA5;
    bus.mcu_addr = 24'h123456; bus.mcu_we = 1'b0; bus.mcu_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mcu_ack) begin ack = 1'b1; break; end
      if (!bus.SRAM_OEn && bus.SRAM_ADDR === 24'h123456) n_oe++;
    end
    bus.mcu_req = 1'b0;
    total++; if (!ack) begin bad++; $display("FAIL mcu_read_ack got=0 exp=1"); end
    total++; if (n_oe != SL) begin bad++; $display("FAIL mcu_read_oe_cycles got=%0d exp=%0d", n_oe, SL); end
    total++; if (bus.mcu_rddata !== 8'hA5) begin bad++; $display("FAIL mcu_read_data got=%h exp=a5", bus.mcu_rddata); end
    total++; if (bus.busy !== 1'b0 || bus.SRAM_OEn !== 1'b1) begin bad++;
      $display("FAIL mcu_read_end busy=%b oen=%b exp=0/1", bus.busy, bus.SRAM_OEn); end
    tick();
    total++; if (bus.mcu_ack !== 1'b0) begin bad++; $display("FAIL mcu_ack_width got=1 exp=0"); end
    dq_force = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_q[$];
    logic [1:0] e;
    logic [1:0] got;
    rr_id_t     last;
    int         n;
    do_reset();
    // two continuously requesting masters must alternate, and reset leaves DMA as the last winner
    last = ID_DMA;
    for (int k = 0; k < 4; k++) begin
      e = (last == ID_DMA) ? 2'b01 : 2'b10;
      exp_q.push_back(e);
      last = (last == ID_DMA) ? ID_MCU : ID_DMA;
    end
    bus.mcu_addr = 24'h000100; bus.mcu_we = 1'b0;
    bus.dma_addr = 24'h000200; bus.dma_we = 1'b0;
    bus.mcu_req = 1'b1; bus.dma_req = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (bus.mcu_ack || bus.dma_ack) begin
        got = {bus.dma_ack, bus.mcu_ack};
        e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL rr_order idx=%0d got=%b exp=%b", n, got, e); end
        total++; if (bus.SRAM_ADDR !== ((e == 2'b01) ? 24'h000100 : 24'h000200)) begin bad++;
          $display("FAIL rr_addr idx=%0d got=%h", n, bus.SRAM_ADDR); end
        n++;
      end
    end
    bus.mcu_req = 1'b0; bus.dma_req = 1'b0;
    total++; if (n != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", n); end
    tick();
  endtask

  task automatic test_write_protect();
    int busy_n, oe_n, we_n, dqoe_n;
    bit seen;
    snes_pulse(24'h7F0040, 1'b1, 1'b0, 8'h3C);
    snes_watch(busy_n, oe_n, we_n, dqoe_n, seen);
    total++; if (!seen) begin bad++; $display("FAIL wp_done got=0 exp=1"); end
    total++; if (we_n != 0 || dqoe_n != 0) begin bad++; $display("FAIL wp_no_write wen_low=%0d dqoe=%0d exp=0/0", we_n, dqoe_n); end
    total++; if (oe_n != SL) begin bad++; $display("FAIL wp_as_read oe=%0d exp=%0d", oe_n, SL); end
    total++; if (bus.snes_rddata !== model_rd(24'h7F0040)) begin bad++;
      $display("FAIL wp_rddata got=%h exp=%h", bus.snes_rddata, model_rd(24'h7F0040)); end
    snes_pulse(24'h7F0040, 1'b1, 1'b1, 8'h3C);
    snes_watch(busy_n, oe_n, we_n, dqoe_n, seen);
    exp_mem[24'h7F0040] = 8'h3C;
    total++; if (!seen) begin bad++; $display("FAIL wr_done got=0 exp=1"); end
    total++; if (we_n != SL - 2) begin bad++; $display("FAIL wr_wen_low got=%0d exp=%0d", we_n, SL - 2); end
    total++; if (dqoe_n != SL || oe_n != 0) begin bad++; $display("FAIL wr_dqoe got=%0d oe=%0d exp=%0d/0", dqoe_n, oe_n, SL); end
    total++; if (bus.snes_rddata !== dflt(8'h40)) begin bad++;
      $display("FAIL wr_rddata_hold got=%h exp=%h", bus.snes_rddata, dflt(8'h40)); end
    snes_pulse(24'h7F0040, 1'b0, 1'b1, 8'h00);
    snes_watch(busy_n, oe_n, we_n, dqoe_n, seen);
    total++; if (!seen || bus.snes_rddata !== model_rd(24'h7F0040)) begin bad++;
      $display("FAIL wr_readback seen=%b got=%h exp=%h", seen, bus.snes_rddata, model_rd(24'h7F0040)); end
  endtask

  task automatic test_slave_block();
    int busy_n, oe_n, we_n, dqoe_n, b;
    bit seen, ack;
    bus.slave_block = 1'b1;
    bus.mcu_addr = 24'h000300; bus.mcu_we = 1'b0; bus.mcu_req = 1'b1;
    b = 0;
    for (int c = 0; c < 10; c++) begin tick(); b += int'(bus.busy) + int'(bus.mcu_ack); end
    total++; if (b != 0) begin bad++; $display("FAIL blk_no_grant busy_or_ack=%0d exp=0", b); end
    snes_pulse(24'h000310, 1'b0, 1'b0, 8'h00);
    snes_watch(busy_n, oe_n, we_n, dqoe_n, seen);
    total++; if (!seen || busy_n != SL) begin bad++; $display("FAIL blk_snes seen=%b busy=%0d exp=1/%0d", seen, busy_n, SL); end
    total++; if (bus.snes_rddata !== dflt(8'h10)) begin bad++;
      $display("FAIL blk_snes_data got=%h exp=%h", bus.snes_rddata, dflt(8'h10)); end
    tick(); tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL blk_after_snes busy=%b exp=0", bus.busy); end
    bus.slave_block = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b1 || dbg_state !== ST_MCU) begin bad++;
      $display("FAIL blk_release busy=%b state=%0d exp=1/%0d", bus.busy, dbg_state, ST_MCU); end
    ack = 1'b0;
    for (int c = 0; c < 20; c++) begin if (bus.mcu_ack) begin ack = 1'b1; break; end tick(); end
    bus.mcu_req = 1'b0;
    total++; if (!ack) begin bad++; $display("FAIL blk_mcu_ack got=0 exp=1"); end
    tick();
  endtask

  task automatic test_snes_preempt();
    bit ack, seen;
    int n;
    bus.dma_addr = 24'h000400; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    tick();
    total++; if (dbg_state !== ST_DMA) begin bad++; $display("FAIL pre_dma_start state=%0d exp=%0d", dbg_state, ST_DMA); end
    tick();
    snes_pulse(24'hE00010, 1'b0, 1'b1, 8'h00);
    ack = 1'b0;
    for (int c = 0; c < 20; c++) begin if (bus.dma_ack) begin ack = 1'b1; break; end tick(); end
    bus.dma_req = 1'b0;
    total++; if (!ack) begin bad++; $display("FAIL pre_dma_ack got=0 exp=1"); end
    tick();
    total++; if (dbg_state !== ST_SNES || bus.SRAM_ADDR !== 24'hE00010) begin bad++;
      $display("FAIL pre_snes_start state=%0d addr=%h exp=%0d/e00010", dbg_state, bus.SRAM_ADDR, ST_SNES); end
    n = 1; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin if (bus.snes_done) begin seen = 1'b1; break; end tick(); n++; end
    total++; if (!seen || n > SL + 1) begin bad++; $display("FAIL pre_snes_latency seen=%b clocks=%0d max=%0d", seen, n, SL + 1); end
    total++; if (bus.snes_rddata !== dflt(8'h10)) begin bad++;
      $display("FAIL pre_snes_data got=%h exp=%h", bus.snes_rddata, dflt(8'h10)); end
  endtask

  task automatic test_reset_mid();
    int acks;
    bit ack;
    bus.mcu_addr = 24'h000080; bus.mcu_we = 1'b1; bus.mcu_wrdata = 8'h77; bus.mcu_req = 1'b1;
    tick(); tick(); tick();
    RST = 1'b1;
    #1;
    total++; if ({bus.SRAM_WEn, bus.SRAM_DQ_OE, bus.busy} !== 3'b100) begin bad++;
      $display("FAIL rstmid_outputs got=%b exp=100", {bus.SRAM_WEn, bus.SRAM_DQ_OE, bus.busy}); end
    bus.mcu_req = 1'b0;
    tick();
    RST = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin tick(); acks += int'(bus.mcu_ack); end
    total++; if (acks != 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    bus.mcu_addr = 24'h000081; bus.mcu_wrdata = 8'h99; bus.mcu_req = 1'b1;
    ack = 1'b0;
    for (int c = 0; c < 20; c++) begin tick(); if (bus.mcu_ack) begin ack = 1'b1; break; end end
    exp_mem[24'h000081] = 8'h99;
    bus.mcu_we = 1'b0;
    for (int c = 0; c < 20; c++) begin tick(); if (bus.mcu_ack) break; end
    bus.mcu_req = 1'b0;
    total++; if (!ack || bus.mcu_rddata !== model_rd(24'h000081)) begin bad++;
      $display("FAIL rstmid_fresh ack=%b got=%h exp=%h", ack, bus.mcu_rddata, model_rd(24'h000081)); end
    tick();
  endtask

  task automatic test_random();
    logic        m_act, d_act, s_out, m_we, d_we, s_eff;
    logic [23:0] m_a, d_a, s_a;
    logic [7:0]  m_d, d_d, s_d;
    int          s_lat;
    m_act = 0; d_act = 0; s_out = 0; m_we = 0; d_we = 0; s_eff = 0;
    m_a = '0; d_a = '0; s_a = '0; m_d = '0; d_d = '0; s_d = '0; s_lat = 0;
    for (int c = 0; c < 900; c++) begin
      tick();
      if (s_out) s_lat++;
      total++; if (!bus.SRAM_OEn && bus.SRAM_DQ_OE) begin bad++; $display("FAIL rnd_bus_clash cycle=%0d oen=0 dq_oe=1", c); end
      if (bus.mcu_ack) begin
        total++;
        if (!m_act) begin bad++; $display("FAIL rnd_mcu_spurious cycle=%0d", c); end
        else if (m_we) exp_mem[m_a] = m_d;
        else if (bus.mcu_rddata !== model_rd(m_a)) begin bad++;
          $display("FAIL rnd_mcu_data addr=%h got=%h exp=%h", m_a, bus.mcu_rddata, model_rd(m_a)); end
        m_act = 0;
      end
      if (bus.dma_ack) begin
        total++;
        if (!d_act) begin bad++; $display("FAIL rnd_dma_spurious cycle=%0d", c); end
        else if (d_we) exp_mem[d_a] = d_d;
        else if (bus.dma_rddata !== model_rd(d_a)) begin bad++;
          $display("FAIL rnd_dma_data addr=%h got=%h exp=%h", d_a, bus.dma_rddata, model_rd(d_a)); end
        d_act = 0;
      end
      if (bus.snes_done) begin
        total++;
        if (!s_out) begin bad++; $display("FAIL rnd_snes_spurious cycle=%0d", c); end
        else if (s_eff) exp_mem[s_a] = s_d;
        else if (bus.snes_rddata !== model_rd(s_a)) begin bad++;
          $display("FAIL rnd_snes_data addr=%h got=%h exp=%h", s_a, bus.snes_rddata, model_rd(s_a)); end
        total++; if (s_lat > 2 * SL + 2) begin bad++; $display("FAIL rnd_snes_latency got=%0d max=%0d", s_lat, 2 * SL + 2); end
        s_out = 0;
      end
      bus.snes_req = 1'b0;
      if (c < 800) begin
        if (!s_out && $urandom_range(0, 7) == 0) begin
          s_a = raddr(); s_d = 8'($urandom_range(0, 255));
          bus.snes_we = 1'($urandom_range(0, 1)); bus.snes_writable = 1'($urandom_range(0, 1));
          s_eff = bus.snes_we & bus.snes_writable;
          bus.snes_addr = s_a; bus.snes_wrdata = s_d; bus.snes_req = 1'b1;
          s_out = 1; s_lat = 0;
        end
        if (!m_act && $urandom_range(0, 2) == 0) begin
          m_a = raddr(); m_we = 1'($urandom_range(0, 1)); m_d = 8'($urandom_range(0, 255)); m_act = 1;
        end
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_a = raddr(); d_we = 1'($urandom_range(0, 1)); d_d = 8'($urandom_range(0, 255)); d_act = 1;
        end
        bus.slave_block = ($urandom_range(0, 5) == 0);
      end else begin
        bus.slave_block = 1'b0;
      end
      bus.mcu_req = m_act; bus.mcu_addr = m_a; bus.mcu_we = m_we; bus.mcu_wrdata = m_d;
      bus.dma_req = d_act; bus.dma_addr = d_a; bus.dma_we = d_we; bus.dma_wrdata = d_d;
    end
    total++; if (m_act || d_act || s_out) begin bad++;
      $display("FAIL rnd_drain outstanding mcu=%b dma=%b snes=%b exp=000", m_act, d_act, s_out); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_mcu_read();
    test_round_robin();
    test_write_protect();
    test_slave_block();
    test_snes_preempt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
